// File: rtl/prbs_checker.sv
// PRBS7/15/23 receive checker: seeds an LFSR from the incoming stream, verifies
// the prediction for LOCK_CNT bits, then free-runs and counts bit errors while locked.
module prbs_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned LOSS_WIN    = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  ctrl_sig,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clr_counts,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] bit_count,
    output logic [31:0] error_count,
    output logic [1:0]  state
);

    localparam int unsigned RunW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW = $clog2(LOSS_WIN + 1);
    localparam int unsigned ErrW = $clog2(LOSS_THRESH + 1);

    localparam logic [RunW-1:0] RunLast = RunW'(LOCK_CNT - 1);
    localparam logic [WinW-1:0] WinLast = WinW'(LOSS_WIN - 1);
    localparam logic [ErrW-1:0] ErrLast = ErrW'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSeed   = 2'd1,
        StVerify = 2'd2,
        StLocked = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [22:0]       r_q, r_d;
    logic [4:0]        seed_q, seed_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [WinW-1:0]   win_q, win_d;
    logic [ErrW-1:0]   werr_q, werr_d;
    logic              err_pulse_q, err_pulse_d;
    logic [31:0]       bit_count_q, bit_count_d;
    logic [31:0]       error_count_q, error_count_d;

    logic        pat_en;
    logic [4:0]  n_bits;
    logic        pred;
    logic [22:0] mask;
    logic        mismatch;

    // Pattern decode: register length, prediction taps and active-bit mask.
    always_comb begin
        pat_en = 1'b1;
        n_bits = 5'd0;
        pred   = 1'b0;
        mask   = '0;
        case (ctrl_sig)
            3'd1: begin
                n_bits = 5'd7;
                pred   = r_q[6] ^ r_q[5];
                mask   = 23'h00007F;
            end
            3'd2: begin
                n_bits = 5'd15;
                pred   = r_q[14] ^ r_q[13];
                mask   = 23'h007FFF;
            end
            3'd3: begin
                n_bits = 5'd23;
                pred   = r_q[22] ^ r_q[17];
                mask   = 23'h7FFFFF;
            end
            default: pat_en = 1'b0;
        endcase
        mismatch = in_bit ^ pred;
    end

    // Next-state: pattern change, seeding, verification and locked error counting.
    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_sig;
        r_d           = r_q;
        seed_d        = seed_q;
        run_d         = run_q;
        win_d         = win_q;
        werr_d        = werr_q;
        err_pulse_d   = 1'b0;
        bit_count_d   = bit_count_q;
        error_count_d = error_count_q;

        if (ctrl_sig != ctrl_q || (!pat_en && state_q != StIdle)) begin
            // Any pattern change restarts acquisition; the current bit is dropped.
            state_d = pat_en ? StSeed : StIdle;
            r_d     = '0;
            seed_d  = '0;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pat_en) begin
                        state_d = StSeed;
                        r_d     = '0;
                        seed_d  = '0;
                    end
                end
                StSeed: begin
                    if (in_valid) begin
                        r_d = {r_q[21:0], in_bit};
                        if (seed_q + 5'd1 == n_bits) begin
                            seed_d = '0;
                            // An all-zero seed would lock onto a dead LFSR.
                            if ((r_d & mask) != '0) begin
                                state_d = StVerify;
                                run_d   = '0;
                            end
                        end else begin
                            seed_d = seed_q + 5'd1;
                        end
                    end
                end
                StVerify: begin
                    if (in_valid) begin
                        r_d = {r_q[21:0], in_bit};
                        if (mismatch) begin
                            state_d = StSeed;
                            run_d   = '0;
                            seed_d  = '0;
                        end else if (run_q == RunLast) begin
                            state_d = StLocked;
                            run_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (in_valid) begin
                        // Free-run on the prediction so a channel error counts once.
                        r_d = {r_q[21:0], pred};
                        if (bit_count_q != 32'hFFFF_FFFF) begin
                            bit_count_d = bit_count_q + 32'd1;
                        end
                        if (mismatch) begin
                            err_pulse_d = 1'b1;
                            if (error_count_q != 32'hFFFF_FFFF) begin
                                error_count_d = error_count_q + 32'd1;
                            end
                        end
                        if (mismatch && werr_q == ErrLast) begin
                            state_d = StSeed;
                            r_d     = '0;
                            seed_d  = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else if (win_q == WinLast) begin
                            win_d  = '0;
                            werr_d = '0;
                        end else begin
                            win_d  = win_q + 1'b1;
                            werr_d = werr_q + ErrW'(mismatch);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (clr_counts) begin
            bit_count_d   = '0;
            error_count_d = '0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            ctrl_q        <= '0;
            r_q           <= '0;
            seed_q        <= '0;
            run_q         <= '0;
            win_q         <= '0;
            werr_q        <= '0;
            err_pulse_q   <= 1'b0;
            bit_count_q   <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            r_q           <= r_d;
            seed_q        <= seed_d;
            run_q         <= run_d;
            win_q         <= win_d;
            werr_q        <= werr_d;
            err_pulse_q   <= err_pulse_d;
            bit_count_q   <= bit_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign locked      = (state_q == StLocked);
    assign err_pulse   = err_pulse_q;
    assign bit_count   = bit_count_q;
    assign error_count = error_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a reference LFSR produces the stream, expected
// error counts are queued per injected error and checked on each err_pulse.
module tb_prbs_checker;

    logic        clock;
    logic        reset;
    logic [2:0]  ctrl_sig;
    logic        in_valid;
    logic        in_bit;
    logic        clr_counts;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_count;
    logic [31:0] error_count;
    logic [1:0]  state;

    prbs_checker dut (
        .clock       (clock),
        .reset       (reset),
        .ctrl_sig    (ctrl_sig),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .clr_counts  (clr_counts),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .bit_count   (bit_count),
        .error_count (error_count),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] sb_q[$];

    logic [22:0] g;
    int          ta_v;
    int          tb_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic start_gen(input int ta, input int tb);
        g    = 23'h1;
        ta_v = ta;
        tb_v = tb;
    endtask

    task automatic send_raw(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Next reference bit, optionally inverted to inject a channel error.
    task automatic send(input logic flip);
        logic b;
        b = g[ta_v-1] ^ g[tb_v-1];
        g = {g[21:0], b};
        send_raw(b ^ flip);
    endtask

    task automatic set_ctrl(input logic [2:0] v);
        ctrl_sig = v;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clr();
        clr_counts = 1'b1;
        in_valid   = 1'b0;
        @(posedge clock);
        #1;
        clr_counts = 1'b0;
    endtask

    // Scoreboard monitor: every err_pulse must match the next queued error count.
    always @(negedge clock) begin
        if (err_pulse) begin
            if (sb_q.size() == 0) chk("err_pulse_unexpected", 32'd1, 32'd0);
            else chk("sb_error_count", error_count, sb_q.pop_front());
        end
    end

    initial begin
        logic [31:0] exp_e;
        logic        any_drop;
        reset      = 1'b1;
        ctrl_sig   = 3'd0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        clr_counts = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_bit_count", bit_count, 32'd0);
        chk("rst_error_count", error_count, 32'd0);

        // PRBS7 acquisition and clean run
        ctrl_sig = 3'd1;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        chk("seed_after_reset", {30'd0, state}, 32'd1);
        start_gen(7, 6);
        repeat (7) send(1'b0);
        chk("p7_verify", {30'd0, state}, 32'd2);
        repeat (15) send(1'b0);
        chk("p7_not_locked_22", {31'd0, locked}, 32'd0);
        send(1'b0);
        chk("p7_locked_23", {31'd0, locked}, 32'd1);
        chk("p7_state_locked", {30'd0, state}, 32'd3);
        repeat (1000) send(1'b0);
        chk("p7_bits_1000", bit_count, 32'd1000);
        chk("p7_errs_0", error_count, 32'd0);

        // Idle gap: nothing advances
        repeat (5) begin
            in_bit = ~in_bit;
            @(posedge clock);
            #1;
        end
        chk("idle_bits_hold", bit_count, 32'd1000);
        chk("idle_no_pulse", {31'd0, err_pulse}, 32'd0);

        // Clear coincident with an error bit: clear wins, pulse still fires
        sb_q.push_back(32'd0);
        clr_counts = 1'b1;
        send(1'b1);
        clr_counts = 1'b0;
        chk("clr_bits_0", bit_count, 32'd0);
        chk("clr_errs_0", error_count, 32'd0);
        chk("clr_err_pulse", {31'd0, err_pulse}, 32'd1);
        sb_q.push_back(32'd1);
        send(1'b1);
        chk("post_clr_errs", error_count, 32'd1);
        repeat (3) send(1'b0);
        chk("post_clr_bits", bit_count, 32'd4);

        // Pattern change 1 -> 3 mid-stream
        set_ctrl(3'd3);
        chk("ctrl_chg_seed", {30'd0, state}, 32'd1);
        chk("ctrl_chg_unlock", {31'd0, locked}, 32'd0);
        chk("ctrl_chg_bits_hold", bit_count, 32'd4);
        chk("ctrl_chg_errs_hold", error_count, 32'd1);

        // PRBS15: sparse errors stay below the loss threshold
        set_ctrl(3'd2);
        start_gen(15, 14);
        do_clr();
        repeat (31) send(1'b0);
        chk("p15_locked", {31'd0, locked}, 32'd1);
        exp_e    = 0;
        any_drop = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i % 20 == 19) begin
                exp_e++;
                sb_q.push_back(exp_e);
                send(1'b1);
            end else begin
                send(1'b0);
            end
            if (!locked) any_drop = 1'b1;
        end
        chk("p15_lock_held", {31'd0, any_drop}, 32'd0);
        chk("p15_errs_10", error_count, 32'd10);
        chk("p15_bits_200", bit_count, 32'd200);

        // PRBS23: burst of 8 errors drops lock, then relock
        set_ctrl(3'd3);
        start_gen(23, 18);
        do_clr();
        repeat (39) send(1'b0);
        chk("p23_locked", {31'd0, locked}, 32'd1);
        repeat (5) send(1'b0);
        exp_e = 0;
        for (int i = 0; i < 8; i++) begin
            exp_e++;
            sb_q.push_back(exp_e);
            send(1'b1);
            if (i == 6) chk("p23_locked_after_7", {31'd0, locked}, 32'd1);
        end
        chk("p23_loss_state", {30'd0, state}, 32'd1);
        chk("p23_loss_locked", {31'd0, locked}, 32'd0);
        chk("p23_loss_bits", bit_count, 32'd13);
        chk("p23_loss_errs", error_count, 32'd8);
        repeat (38) send(1'b0);
        chk("p23_relock_not_yet", {31'd0, locked}, 32'd0);
        send(1'b0);
        chk("p23_relocked", {31'd0, locked}, 32'd1);
        chk("p23_bits_retained", bit_count, 32'd13);
        chk("p23_errs_retained", error_count, 32'd8);

        // PRBS15 with an all-zero stream never leaves SEED
        set_ctrl(3'd2);
        do_clr();
        repeat (100) send_raw(1'b0);
        chk("zero_state_seed", {30'd0, state}, 32'd1);
        chk("zero_unlocked", {31'd0, locked}, 32'd0);
        chk("zero_bits", bit_count, 32'd0);
        chk("zero_errs", error_count, 32'd0);

        // Saturation of bit_count
        set_ctrl(3'd1);
        start_gen(7, 6);
        repeat (23) send(1'b0);
        chk("sat_locked", {31'd0, locked}, 32'd1);
        do_clr();
        force dut.bit_count_q = 32'hFFFF_FFF0;
        #1;
        release dut.bit_count_q;
        repeat (15) send(1'b0);
        chk("sat_reach", bit_count, 32'hFFFF_FFFF);
        repeat (10) send(1'b0);
        chk("sat_hold", bit_count, 32'hFFFF_FFFF);

        // Reset mid-LOCKED
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst2_state", {30'd0, state}, 32'd0);
        chk("rst2_locked", {31'd0, locked}, 32'd0);
        chk("rst2_bits", bit_count, 32'd0);
        chk("rst2_errs", error_count, 32'd0);
        chk("rst2_err_pulse", {31'd0, err_pulse}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst2_seed", {30'd0, state}, 32'd1);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
